rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Eight-requester round-robin arbiter with grant hold, upstream of the team's 3-to-8 decoder. Produces a registered 3-bit grant index plus a valid flag. The decoder expands the index into the one-hot grant vector returned to requesters. Fair rotation prevents starvation; an optional timeout bounds how long one requester can hold the grant.

## Interface
- MAX_HOLD, 16, maximum consecutive GRANT cycles per holder before forced rotation (used only with timeout compiled in); legal range 2..255
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector, bit i = requester i; level-sensitive
- grant_valid  output  1  a grant is active this cycle
- grant_idx  output  3  index of current holder; drives decoder input
- timeout_flag  output  1  one-cycle pulse on forced rotation

## Operation
- Registered state: fsm (IDLE, GRANT), grant_idx, grant_valid, ptr[2:0] (first index searched on next arbitration), hold_cnt (timeout builds only).
- Arbitration picks the first set bit of req scanning ptr, ptr+1, ... ptr+7, wrapping modulo 8. One candidate is optionally masked out.
- IDLE:
  - If req == 0, stay.
  - Else pick the winner w, set grant_idx=w, grant_valid=1, ptr=w+1 (mod 8), go to GRANT.
- GRANT, holder h = grant_idx:
  - req[h]=1 and no timeout: hold; all outputs unchanged; other requests ignored.
  - Release when req[h]=0. Arbitrate over req with bit h masked, starting at h+1.
    - Winner found: back-to-back grant to the winner next cycle; grant_valid stays 1.
    - No winner: grant_valid=0, go to IDLE. grant_idx keeps its last value.
- Wrap-around: h=7 gives start 0.
- Requests changing while held do not disturb the holder.
- grant_idx is meaningful only when grant_valid=1.
- Reset values: fsm=IDLE, grant_valid=0, grant_idx=0, ptr=0, hold_cnt=0, timeout_flag=0. Reset wins over all other events.
  - Reset mid-grant drops grant_valid at the next edge.
  - Priority restarts at requester 0.

## Timing
- Latency from request to grant in IDLE is 1 cycle. req sampled at edge N gives grant_valid=1 after edge N+1... more precisely, req high before edge N gives grant_valid=1 from edge N.
- Release latency is 1 cycle. req[h] low at edge N means the new holder (or grant_valid=0) appears from edge N.
- No idle bubble between back-to-back grants.
- All outputs are registered; there is no combinational path from req to outputs.
- Downstream decoder adds no cycle; its one-hot output is aligned with grant_idx.

## Configuration
- Macro: RR_ARBITER_TIMEOUT_EN.
- Defined:
  - hold_cnt clears on every new grant and increments each GRANT cycle with req[h]=1.
  - When hold_cnt == MAX_HOLD-1 and req[h] is still 1, force a release exactly as if req[h]=0, with h masked.
  - In that cycle, pulse timeout_flag=1 for one cycle.
  - If no other requester exists, the holder is re-granted, hold_cnt clears, and the flag still pulses.
- Undefined: hold_cnt is absent, timeout_flag is tied to 0, and holding is unbounded.
- The MAX_HOLD parameter exists in both builds.

## Structure
- Package rr_arbiter_pkg:
  - NUM_REQ=8
  - IDX_W=3
  - state enum {IDLE, GRANT}
  - HOLD_W derived from MAX_HOLD (8 bits covers the legal range)
- Sub-module rr_pick (purely combinational):
  - Inputs: req[7:0], start[2:0], mask_en, mask_idx[2:0].
  - Outputs: found, idx[2:0].
  - One instance serves both IDLE and release arbitration.
- Top module holds the FSM, ptr, hold counter and output registers.

## Test plan
- Reset with req=8'hFF, then release rst: grant_idx=0, valid=1 one cycle after rst falls. Drop req[0]: next grant is 1, then 2, ... 7, then 0 (wrap).
- Only req[5] held for 20 cycles, other bits toggled randomly: grant_idx stays 5 and valid stays 1 throughout (timeout undefined).
- Holder 3 drops req with req=8'h00: valid=0 next cycle, fsm IDLE. Then req=8'h01: grant 0 after 1 cycle, ptr=1.
- Holder 6 drops req while req[1] and req[7] are high: grant 7 with no gap. Then on release, grant 1.
- RR_ARBITER_TIMEOUT_EN defined, MAX_HOLD=4, req=8'h09, holder 0: after 4 GRANT cycles, timeout_flag pulses once and the grant moves to 3.
- Assert rst for one cycle mid-grant with req=8'hFF: grant_valid=0 and grant_idx=0 in the next cycle, then grant 0 is re-issued.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared widths and FSM state type for the 8-requester round-robin arbiter.
package rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Combinational round-robin search: first set request at or after start, with
// one optional index excluded from the search.
module rr_pick
    import rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    input  logic               mask_en,
    input  logic [IDX_W-1:0]   mask_idx,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the far end back toward start so the nearest candidate wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (req[cand] && !(mask_en && (cand == mask_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with grant hold and registered index output.
// Optional hold timeout is compiled in with RR_ARBITER_TIMEOUT_EN.
module rr_arbiter_8
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               timeout_flag
);

    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be within 2..255");
    end

    state_e           state, state_nxt;
    logic             valid_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;

    logic [IDX_W-1:0] pick_start;
    logic             pick_mask_en;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    logic             holder_req;
    logic             force_rel;

    assign holder_req = req[grant_idx];

    // Shared picker: idle search starts at ptr; release search skips the holder.
    always_comb begin
        pick_start   = ptr;
        pick_mask_en = 1'b0;
        if (state == GRANT) begin
            pick_start   = grant_idx + IDX_W'(1);
            pick_mask_en = 1'b1;
        end
    end

    rr_pick u_pick (
        .req      (req),
        .start    (pick_start),
        .mask_en  (pick_mask_en),
        .mask_idx (grant_idx),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        valid_nxt = grant_valid;
        idx_nxt   = grant_idx;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    valid_nxt = 1'b1;
                    idx_nxt   = pick_idx;
                    ptr_nxt   = pick_idx + IDX_W'(1);
                end
            end
            GRANT: begin
                if (!holder_req || force_rel) begin
                    if (pick_found) begin
                        idx_nxt = pick_idx;
                        ptr_nxt = pick_idx + IDX_W'(1);
                    end else if (force_rel) begin
                        // Lone requester timed out: re-grant it with a fresh count.
                        ptr_nxt = grant_idx + IDX_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= '0;
        end else begin
            state       <= state_nxt;
            grant_valid <= valid_nxt;
            grant_idx   <= idx_nxt;
            ptr         <= ptr_nxt;
        end
    end

`ifdef RR_ARBITER_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              flag_nxt;

    assign force_rel = holder_req && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Count only uninterrupted holding cycles; any hand-over restarts at zero.
    always_comb begin
        hold_cnt_nxt = '0;
        flag_nxt     = 1'b0;
        if (state == GRANT) begin
            flag_nxt = force_rel;
            if (holder_req && !force_rel) begin
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            hold_cnt     <= hold_cnt_nxt;
            timeout_flag <= flag_nxt;
        end
    end
`else
    assign force_rel    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Randomized and directed bench for rr_arbiter_8 against a rule-level reference model.
module tb_rr_arbiter_8;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam bit          TO_EN       = 1'b1;
    localparam int unsigned TB_MAX_HOLD = 4;
`else
    localparam bit          TO_EN       = 1'b0;
    localparam int unsigned TB_MAX_HOLD = 16;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout_flag;

    int n_cmp;
    int n_bad;

    // Reference model: who holds, since how long, and where the next search starts.
    int m_valid;
    int m_idx;
    int m_ptr;
    int m_cnt;
    int m_flag;

    logic [4:0] exp_v;
    logic [4:0] act_v;

    rr_arbiter_8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .timeout_flag (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_grant(int w);
        m_valid = 1;
        m_idx   = w;
        m_ptr   = (w + 1) % 8;
        m_cnt   = 0;
    endfunction

    function automatic void model_step(logic [7:0] r, logic rs);
        int  h;
        bit  timed;
        bit  found;
        if (rs) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_flag = 0;
            return;
        end
        m_flag = 0;
        if (m_valid == 0) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                if (!found && r[(m_ptr + k) % 8]) begin
                    model_grant((m_ptr + k) % 8);
                    found = 1;
                end
            end
        end else begin
            h     = m_idx;
            timed = TO_EN && r[h] && (m_cnt == int'(TB_MAX_HOLD) - 1);
            if (r[h] && !timed) begin
                m_cnt++;
            end else begin
                found = 0;
                for (int k = 1; k < 8; k++) begin
                    if (!found && r[(h + k) % 8]) begin
                        model_grant((h + k) % 8);
                        found = 1;
                    end
                end
                if (!found) begin
                    if (timed) model_grant(h);
                    else m_valid = 0;
                end
                m_flag = timed ? 1 : 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(req, rst);
        #1;
        exp_v = {m_valid[0], m_idx[2:0], m_flag[0]};
        act_v = {grant_valid, grant_idx, timeout_flag};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (act_v !== 5'b0_000_0) begin
                n_bad++;
                $display("FAIL reset: valid/idx/flag got %b want 0_000_0", act_v);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (act_v !== exp_v || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_grant: got %b want %b", act_v, exp_v);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] want;
        for (int i = 0; i < 8; i++) begin
            req  = 8'hFF & ~(8'h01 << i);
            want = 3'((i + 1) % 8);
            tick();
            n_cmp++;
            if (act_v !== exp_v || grant_idx !== want || grant_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL rotation step %0d: got %b idx %0d want %b idx %0d",
                         i, act_v, grant_idx, exp_v, want);
            end
        end
    endtask

    task automatic test_hold();
        req = 8'h20;
        tick();
        for (int i = 0; i < 20; i++) begin
            req = 8'($urandom) | 8'h20;
            tick();
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL hold cycle %0d: got %b want %b", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_idle();
        logic [7:0] seq [6] = '{8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            req = seq[i];
            tick();
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL idle step %0d req %h: got %b want %b", i, seq[i], act_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4] = '{8'h00, 8'h40, 8'h82, 8'h02};
        for (int i = 0; i < 4; i++) begin
            req = seq[i];
            tick();
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL back_to_back step %0d req %h: got %b want %b",
                         i, seq[i], act_v, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        req = 8'h09;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL timeout cycle %0d: got %b want %b", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        req = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (act_v !== exp_v || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got %b want %b", act_v, exp_v);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (act_v !== exp_v || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_regrant: got %b want %b", act_v, exp_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0: req = 8'h00;
                1: req = 8'h01 << $urandom_range(0, 7);
                default: req = 8'($urandom);
            endcase
            tick();
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL random cycle %0d req %h rst %b: got %b want %b",
                         i, req, rst, act_v, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 8'h00;
        m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_flag = 0;
        exp_v = '0;
        act_v = '0;
        #1;
        test_reset();
        test_rotation();
        test_hold();
        test_idle();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
